neo_memcard_resp: RTL
=====================

NEO_MEMCARD_RESP -- requirements
Module: neo_memcard_resp

Interface
REQ-001 Parameter CARD_AW, default 11, sets card byte-address width (2 KiB card); legal range 11..21.
REQ-002 CLK  input  1  sole clock; all logic on rising edge.
REQ-003 RESET  input  1  reset; asynchronous and active-high.
REQ-004 CDA  input  24  card byte address: {bank[2:0], 68k word address[21:1]}; one byte per 68k word.
REQ-005 nCRDC  input  1  card chip select, active low, already synchronous to CLK.
REQ-006 nCARDOE  input  1  card read strobe, active low.
REQ-007 nCARDWE  input  1  card write strobe, active low.
REQ-008 CARD_DIN  input  8  write data, lower byte of the 68k data bus.
REQ-009 CARD_DOUT  output  8  read data returned to the 68k bus.
REQ-010 nCARD_WAIT  output  1  low while an access is in progress; the bus stalls until it is high.
REQ-011 CARD_PRESENT  input  1  high = card inserted.
REQ-012 CARD_WP  input  1  high = card write-protected.
REQ-013 MEM_ADDR  output  CARD_AW  backing-store byte address.
REQ-014 MEM_WDATA  output  8  backing-store write data.
REQ-015 MEM_WE  output  1  high = current request is a write.
REQ-016 MEM_REQ  output  1  backing-store request, level, held until acknowledged.
REQ-017 MEM_ACK  input  1  one-cycle acknowledge from the backing store.
REQ-018 MEM_RDATA  input  8  read data, valid in the MEM_ACK cycle.
REQ-019 DIRTY  output  1  high = card contents modified since the last save.
REQ-020 DIRTY_CLR  input  1  one-cycle pulse from the save logic.

Function
REQ-021 State machine with four states: IDLE, RD, WR, HOLD.
REQ-022 Access start = registered nCRDC previously 1 and currently 0, sampled in IDLE only.
REQ-023 At start, nCARDWE low -> write; else nCARDOE low -> read; neither -> HOLD with no access; both low -> write.
REQ-024 Read start with CARD_PRESENT=1: same edge enters RD, sets MEM_REQ=1, MEM_WE=0, MEM_ADDR=CDA[CARD_AW-1:0], nCARD_WAIT=0.
REQ-025 Write start with CARD_PRESENT=1 and CARD_WP=0: same edge enters WR, sets MEM_REQ=1, MEM_WE=1, MEM_WDATA=CARD_DIN, MEM_ADDR as REQ-024, nCARD_WAIT=0.
REQ-026 Addresses beyond capacity wrap: upper CDA bits are ignored, so the card is mirrored across the area.
REQ-027 MEM_ADDR, MEM_WDATA and MEM_WE hold stable while MEM_REQ=1.
REQ-028 In RD or WR, the edge sampling MEM_ACK=1: MEM_REQ->0, nCARD_WAIT->1, state->HOLD; in RD, CARD_DOUT<=MEM_RDATA.
REQ-029 Minimum access latency: 2 edges from start to nCARD_WAIT high (ACK in the cycle after the request).
REQ-030 Read with CARD_PRESENT=0: CARD_DOUT<=8'hFF, no MEM_REQ, nCARD_WAIT stays 1, state->HOLD.
REQ-031 Write with CARD_PRESENT=0 or CARD_WP=1: discarded, no MEM_REQ, nCARD_WAIT stays 1, DIRTY unchanged, state->HOLD.
REQ-032 CARD_DOUT holds its last value until the next completed read.
REQ-033 HOLD -> IDLE on the first edge sampling nCRDC=1; no new access while in HOLD.
REQ-034 nCRDC deasserted during RD or WR: the memory transaction still completes; on ACK the state goes directly to IDLE.
REQ-035 CARD_PRESENT or CARD_WP changing during RD or WR does not abort the transaction.
REQ-036 DIRTY set on the edge that completes a WR with MEM_ACK.
REQ-037 DIRTY_CLR clears DIRTY; if it coincides with a WR completion, DIRTY ends 1 (set wins).

Reset
REQ-038 RESET asserted: state=IDLE, MEM_REQ=0, MEM_WE=0, MEM_ADDR=0, MEM_WDATA=0, CARD_DOUT=8'hFF, nCARD_WAIT=1, DIRTY=0, registered nCRDC=1.
REQ-039 RESET during RD or WR abandons the request immediately; a late MEM_ACK after release is ignored in IDLE.
REQ-040 After RESET, an nCRDC already low is not an edge; an access needs nCRDC to go high, then low.

Verification
REQ-041 Read: CDA=24'h000123, nCARDOE=0, nCRDC falls, ACK one cycle later with MEM_RDATA=8'h5A -> MEM_ADDR=11'h123, CARD_DOUT=8'h5A, nCARD_WAIT low exactly 2 cycles.
REQ-042 Write/wrap: CDA=24'h200805, CARD_DIN=8'hC3, nCARDWE=0 -> MEM_ADDR=11'h005, MEM_WDATA=8'hC3, MEM_WE=1, DIRTY=1 after ACK; DIRTY_CLR pulse -> DIRTY=0.
REQ-043 Protection: CARD_WP=1 write -> no MEM_REQ, DIRTY stays 0; CARD_PRESENT=0 read -> CARD_DOUT=8'hFF, nCARD_WAIT never low.
REQ-044 Coincidence: DIRTY_CLR on the WR ACK edge -> DIRTY=1.
REQ-045 Abort: nCRDC rises during RD with ACK delayed 5 cycles -> MEM_REQ held to ACK, then IDLE; RESET during WR -> MEM_REQ=0 at once, later ACK has no effect.
REQ-046 Hold: nCRDC held low 10 cycles after one access -> exactly one MEM_REQ.

Source files
------------

// File: rtl/neo_memcard_resp.sv
// Memory-card bus responder: turns 68k card cycles into byte requests to a
// backing store, inserts wait states until the store acknowledges, tracks dirty.
module neo_memcard_resp #(
  parameter int CARD_AW = 11
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic [23:0]        CDA,
  input  logic               nCRDC,
  input  logic               nCARDOE,
  input  logic               nCARDWE,
  input  logic [7:0]         CARD_DIN,
  output logic [7:0]         CARD_DOUT,
  output logic               nCARD_WAIT,
  input  logic               CARD_PRESENT,
  input  logic               CARD_WP,
  output logic [CARD_AW-1:0] MEM_ADDR,
  output logic [7:0]         MEM_WDATA,
  output logic               MEM_WE,
  output logic               MEM_REQ,
  input  logic               MEM_ACK,
  input  logic [7:0]         MEM_RDATA,
  output logic               DIRTY,
  input  logic               DIRTY_CLR
);

  // state | meaning
  // IDLE  | waiting for a falling edge of nCRDC
  // RD    | read request outstanding to the backing store
  // WR    | write request outstanding to the backing store
  // HOLD  | access finished or refused, waiting for nCRDC to release
  typedef enum logic [1:0] {IDLE, RD, WR, HOLD} state_t;

  state_t state;
  logic   crdc_q;
  logic   armed;
  logic   start;
  logic   unused_cda;

  // Upper address bits are dropped so the card mirrors across the whole area.
  assign unused_cda = &{1'b0, CDA[23:CARD_AW]};

  // armed blocks a select that was already low when reset released from
  // counting as a falling edge.
  assign start = (state == IDLE) && armed && crdc_q && !nCRDC;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state      <= IDLE;
      crdc_q     <= 1'b1;
      armed      <= 1'b0;
      MEM_REQ    <= 1'b0;
      MEM_WE     <= 1'b0;
      MEM_ADDR   <= '0;
      MEM_WDATA  <= 8'h00;
      CARD_DOUT  <= 8'hFF;
      nCARD_WAIT <= 1'b1;
      DIRTY      <= 1'b0;
    end else begin
      crdc_q <= nCRDC;
      if (nCRDC) armed <= 1'b1;
      if (DIRTY_CLR) DIRTY <= 1'b0;

      case (state)
        IDLE: begin
          if (start) begin
            if (!nCARDWE) begin
              if (CARD_PRESENT && !CARD_WP) begin
                state      <= WR;
                MEM_REQ    <= 1'b1;
                MEM_WE     <= 1'b1;
                MEM_WDATA  <= CARD_DIN;
                MEM_ADDR   <= CDA[CARD_AW-1:0];
                nCARD_WAIT <= 1'b0;
              end else begin
                state <= HOLD;
              end
            end else if (!nCARDOE) begin
              if (CARD_PRESENT) begin
                state      <= RD;
                MEM_REQ    <= 1'b1;
                MEM_WE     <= 1'b0;
                MEM_ADDR   <= CDA[CARD_AW-1:0];
                nCARD_WAIT <= 1'b0;
              end else begin
                CARD_DOUT <= 8'hFF;
                state     <= HOLD;
              end
            end else begin
              state <= HOLD;
            end
          end
        end
        RD, WR: begin
          // The store transaction always completes even if the 68k let go.
          if (MEM_ACK) begin
            MEM_REQ    <= 1'b0;
            nCARD_WAIT <= 1'b1;
            state      <= nCRDC ? IDLE : HOLD;
            if (state == RD) CARD_DOUT <= MEM_RDATA;
            else             DIRTY     <= 1'b1;
          end
        end
        HOLD: begin
          if (nCRDC) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
